// File: rtl/mem_stage_waitstate.sv
// rtl/mem_stage_waitstate.sv - MEM stage with multi-cycle data memory and pipeline freeze (optional MEM_ALIGN_CHECK_EN)
module mem_stage_waitstate #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 3,
    parameter int BASE_ADDR = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rm_val,
    input  logic [3:0]        dest_in,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] data_memory_out,
    output logic [3:0]        dest,
    output logic              ready,
    output logic              misaligned
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dmo;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_offset;
    logic [IDX_W-1:0]  w_idx;
    logic              w_req;
    logic              w_misalign;
    logic              w_start;
    logic              w_commit;
    logic              w_store;
    logic              w_load;
    logic              w_unused;

    // Out-of-range addresses simply wrap onto the memory; there is no bus error.
    assign w_offset = alu_result - DATA_W'(BASE_ADDR);
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_unused = ^{w_offset[DATA_W-1:IDX_W+2], w_offset[1:0]};

    assign w_req = mem_r_en_in | mem_w_en_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (r_state == S_IDLE) && w_req && (alu_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start  = (r_state == S_IDLE) && w_req && !w_misalign;
    // Commit on the edge that enters DONE, so the stage presents results during DONE.
    assign w_commit = (w_start && (LATENCY == 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == '0));
    assign w_store  = w_commit && mem_w_en_in;
    assign w_load   = w_commit && mem_r_en_in && !mem_w_en_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dmo   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_store) begin
                r_mem[w_idx] <= rm_val;
            end
            if (w_load) begin
                r_dmo <= r_mem[w_idx];
            end
        end
    end

    assign ready = !(w_start || (r_state == S_WAIT));

    // WB sees a bubble for every frozen cycle.
    assign wb_en           = wb_en_in & ready;
    assign mem_r_en        = mem_r_en_in;
    assign mem_w_en        = mem_w_en_in;
    assign alu_result_out  = alu_result;
    assign dest            = dest_in;
    assign data_memory_out = r_dmo;
    assign misaligned      = w_misalign;

endmodule

// File: tb/tb_mem_stage_waitstate.sv
// tb/tb_mem_stage_waitstate.sv - scoreboard bench for mem_stage_waitstate
module tb_mem_stage_waitstate;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_result;
    logic [31:0] rm_val;
    logic [3:0]  dest_in;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result_out;
    logic [31:0] data_memory_out;
    logic [3:0]  dest;
    logic        ready;
    logic        misaligned;

    mem_stage_waitstate #(
        .DATA_W(32), .DEPTH(64), .LATENCY(3), .BASE_ADDR(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result(alu_result), .rm_val(rm_val), .dest_in(dest_in),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result_out(alu_result_out), .data_memory_out(data_memory_out),
        .dest(dest), .ready(ready), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          stalls;
        logic [31:0] dmo;
        logic        mis;
        logic        wb;
        logic [3:0]  dst;
        logic [31:0] alu;
        logic        r;
        logic        w;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor: counts frozen cycles of the held request and checks at the release cycle.
    initial begin
        int   stalls    = 0;
        logic wb_bad    = 1'b0;
        int   cyc       = 0;
        int   last_done = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                stalls = 0;
                wb_bad = 1'b0;
            end else if (mem_r_en_in || mem_w_en_in) begin
                if (!ready) begin
                    stalls++;
                    if (wb_en) wb_bad = 1'b1;
                end else if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_completion: got completion at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".stalls"}, stalls, e.stalls);
                    check({e.name, ".dmo"}, data_memory_out, e.dmo);
                    check({e.name, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
                    check({e.name, ".wb_en"}, {31'd0, wb_en}, {31'd0, e.wb});
                    check({e.name, ".wb_stall"}, {31'd0, wb_bad}, 32'd0);
                    check({e.name, ".dest"}, {28'd0, dest}, {28'd0, e.dst});
                    check({e.name, ".alu_out"}, alu_result_out, e.alu);
                    check({e.name, ".rw"}, {30'd0, mem_r_en, mem_w_en}, {30'd0, e.r, e.w});
                    if (e.gap != 0) check({e.name, ".gap"}, cyc - last_done, e.gap);
                    last_done = cyc;
                    stalls    = 0;
                    wb_bad    = 1'b0;
                end
            end
        end
    end

    task automatic op(input string name, input logic r, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] d, input logic wb,
                      input int stalls, input logic [31:0] dmo, input logic mis, input int gap);
        exp_t e;
        bit   done = 1'b0;
        e = '{name, stalls, dmo, mis, wb, d, addr, r, w, gap};
        sb.push_back(e);
        mem_r_en_in = r;
        mem_w_en_in = w;
        alu_result  = addr;
        rm_val      = data;
        dest_in     = d;
        wb_en_in    = wb;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL %s.timeout: got ready=0 for 20 cycles expected release", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        wb_en_in    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        alu_result = 32'd0;
        rm_val     = 32'd0;
        dest_in    = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset.dmo", data_memory_out, 32'd0);
        check("reset.ready", {31'd0, ready}, 32'd1);
        check("reset.misaligned", {31'd0, misaligned}, 32'd0);
        @(posedge clk); #1;

        op("ld1024_rst", 1, 0, 32'd1024, 32'd0, 4'd1, 1, 3, 32'd0, 0, 0);
        idle(); @(posedge clk); #1;

        op("st_beef", 0, 1, 32'd1028, 32'hDEADBEEF, 4'd2, 1, 3, 32'd0, 0, 0);
        op("ld_beef", 1, 0, 32'd1028, 32'd0, 4'd3, 1, 3, 32'hDEADBEEF, 0, 4);
        idle(); @(posedge clk); #1;

        op("st_11", 0, 1, 32'd1024, 32'h11, 4'd4, 0, 3, 32'hDEADBEEF, 0, 0);
        op("st_22", 0, 1, 32'd1028, 32'h22, 4'd5, 0, 3, 32'hDEADBEEF, 0, 4);
        op("ld_11", 1, 0, 32'd1024, 32'd0, 4'd6, 1, 3, 32'h11, 0, 4);
        op("ld_22", 1, 0, 32'd1028, 32'd0, 4'd7, 1, 3, 32'h22, 0, 4);
        idle(); @(posedge clk); #1;

        op("st_wrap_rw", 1, 1, 32'd1280, 32'h55, 4'd8, 1, 3, 32'h22, 0, 0);
        op("ld_wrap", 1, 0, 32'd1024, 32'd0, 4'd9, 1, 3, 32'h55, 0, 4);
        idle(); @(posedge clk); #1;

        // Store aborted by reset while in WAIT; nothing is expected from it.
        mem_w_en_in = 1'b1;
        alu_result  = 32'd1032;
        rm_val      = 32'h99;
        dest_in     = 4'd10;
        @(negedge clk);
        @(negedge clk);
        check("midrst.wait_stall", {31'd0, ready}, 32'd0);
        #1 rst = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst.ready", {31'd0, ready}, 32'd1);
        check("midrst.dmo", data_memory_out, 32'd0);
        @(posedge clk); #1;

        op("ld1032_after_rst", 1, 0, 32'd1032, 32'd0, 4'd11, 1, 3, 32'd0, 0, 0);
        op("ld_wrap_after_rst", 1, 0, 32'd1024, 32'd0, 4'd12, 1, 3, 32'd0, 0, 4);
        idle(); @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
        op("st_misal", 0, 1, 32'd1026, 32'h77, 4'd13, 1, 0, 32'd0, 1, 0);
        op("ld_misal", 1, 0, 32'd1024, 32'd0, 4'd14, 1, 3, 32'd0, 0, 0);
`else
        op("st_misal", 0, 1, 32'd1026, 32'h77, 4'd13, 1, 3, 32'd0, 0, 0);
        op("ld_misal", 1, 0, 32'd1024, 32'd0, 4'd14, 1, 3, 32'h77, 0, 4);
`endif
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
        $fatal(1, "watchdog");
    end

endmodule
